m_cargador_registros: RTL

M_CARGADOR_REGISTROS -- requirements
Module: m_cargador_registros

---
 rtl/m_registros_pkg.sv | 23 ++
 rtl/m_contador_direccion.sv | 28 ++
 rtl/m_cargador_registros.sv | 113 +++++++++++
 3 files changed

// File: rtl/m_registros_pkg.sv
// Shared widths, sizes and FSM encoding for the register-file loader.
// States are plain localparams so legacy code can compare against raw values.
package m_registros_pkg;

  localparam int ANCHO_DATO = 32;
  localparam int ANCHO_DIR  = 5;
  localparam int NUM_REGS   = 32;
  localparam int ANCHO_CANT = 6;

  typedef logic [1:0] estado_t;

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] CARGA  = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  localparam logic [ANCHO_CANT-1:0] CANTIDAD_MAX = 6'd32;

  // Requests above the register-file depth load the whole file once.
  function automatic logic [ANCHO_CANT-1:0] saturar_cantidad(input logic [ANCHO_CANT-1:0] c);
    return (c > CANTIDAD_MAX) ? CANTIDAD_MAX : c;
  endfunction

endpackage

// File: rtl/m_contador_direccion.sv
// Loadable write-address counter; increments by one and wraps at NUM_REGS.
// Load has priority over increment; no internal latency beyond the register.
module m_contador_direccion
  import m_registros_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cargar,
  input  logic                 incrementar,
  input  logic [ANCHO_DIR-1:0] valor_carga,
  output logic [ANCHO_DIR-1:0] cuenta
);

  localparam logic [ANCHO_DIR-1:0] ULTIMA = ANCHO_DIR'(NUM_REGS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta <= '0;
    end else if (cargar) begin
      cuenta <= valor_carga;
    end else if (incrementar) begin
      cuenta <= (cuenta == ULTIMA) ? '0 : cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/m_cargador_registros.sv
// Streams a burst of words into consecutive register-file entries, one WE per accepted word (latency 1).
// Optional running XOR of the burst when CARGADOR_CHECKSUM_EN is defined; otherwise checksum is tied to 0.
module m_cargador_registros
  import m_registros_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ANCHO    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iniciar,
  input  logic [ANCHO_DIR-1:0]  direccionInicial,
  input  logic [ANCHO_CANT-1:0] cantidad,
  input  logic [ANCHO-1:0]      datosEntrada,
  input  logic                  validoEntrada,
  output logic                  listoEntrada,
  output logic                  WE,
  output logic [ANCHO_DIR-1:0]  direccionEscritura,
  output logic [ANCHO-1:0]      datos,
  output logic                  ocupado,
  output logic                  terminado,
  output logic [ANCHO-1:0]      checksum
);

  estado_t               estado;
  estado_t               estado_sig;
  logic [ANCHO_CANT-1:0] restantes;
  logic [ANCHO_DIR-1:0]  direccion_actual;
  logic                  aceptar_inicio;
  logic                  transferencia;
  logic                  ultima;

  assign aceptar_inicio = (estado == REPOSO) && iniciar && (cantidad != '0);
  assign transferencia  = (estado == CARGA) && validoEntrada;
  assign ultima         = transferencia && (restantes == 6'd1);

  assign listoEntrada = (estado == CARGA);
  assign ocupado      = (estado != REPOSO);
  assign terminado    = (estado == FIN);

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (aceptar_inicio) estado_sig = CARGA;
      CARGA:   if (ultima) estado_sig = FIN;
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      restantes <= '0;
    end else if (aceptar_inicio) begin
      restantes <= saturar_cantidad(cantidad);
    end else if (transferencia) begin
      restantes <= restantes - 1'b1;
    end
  end

  m_contador_direccion #(
    .NUM_REGS (NUM_REGS)
  ) u_contador (
    .clk         (clk),
    .rst         (rst),
    .cargar      (aceptar_inicio),
    .incrementar (transferencia),
    .valor_carga (direccionInicial),
    .cuenta      (direccion_actual)
  );

  // Address and data hold their last value between pulses; only WE returns to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE                 <= 1'b0;
      direccionEscritura <= '0;
      datos              <= '0;
    end else begin
      WE <= transferencia;
      if (transferencia) begin
        direccionEscritura <= direccion_actual;
        datos              <= datosEntrada;
      end
    end
  end

`ifdef CARGADOR_CHECKSUM_EN
  logic [ANCHO-1:0] acumulado;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acumulado <= '0;
    end else if (aceptar_inicio) begin
      acumulado <= '0;
    end else if (transferencia) begin
      acumulado <= acumulado ^ datosEntrada;
    end
  end

  assign checksum = acumulado;
`else
  assign checksum = '0;
`endif

endmodule
